imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader on the write side of the instruction memory that the pipelined CPU fetches from. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them to consecutive instruction-memory word slots starting at byte address 0. Loading stops at the end-of-program sentinel 32'hFFFF_FFFF, which the CPU's fetch stage detects. The loader holds the CPU in reset while loading, releases it to run, and re-holds it when the CPU raises `end_program`.

## Interface
- `DEPTH`, 256: instruction-memory capacity in 32-bit words; power of two, at least 2.
- `CNT_W`, 32: width of the run-cycle counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte on `in_data` is valid.
- `in_data` input 8: program byte.
- `in_ready` output 1: loader accepts a byte this cycle; a byte transfers when `in_valid & in_ready`.
- `end_program` input 1: CPU end-of-program flag.
- `restart` input 1: single-cycle request to reload; honoured only in HALT or ERR.
- `imem_we` output 1: one-cycle instruction-memory write strobe.
- `imem_addr` output 64: byte address of the write, always equal to word index × 4.
- `imem_wdata` output 32: instruction word to write.
- `cpu_reset` output 1: active-high reset to the CPU; 1 in every state except RUN.
- `words_loaded` output clog2(DEPTH)+1: number of words written in the current load, including the sentinel.
- `run_cycles` output CNT_W: number of cycles spent in RUN; saturates at all-ones.
- `done` output 1: high in HALT.
- `error` output 1: high in ERR.

## Operation
- States:
  - LOAD (reset state).
  - FLUSH (one cycle; the sentinel write retires).
  - RUN.
  - HALT.
  - ERR.
- `in_ready` = (state == LOAD), decoded combinationally from the state register. `in_valid` is ignored in every other state.
- LOAD byte packing:
  - A 2-bit byte counter `bc` selects the lane; an accepted byte goes to bits [8*bc+7 : 8*bc] of the assembly register.
  - `bc` wraps 3→0.
- On the edge that accepts the 4th byte (bc == 3):
  - Register `imem_we`=1, `imem_wdata`={byte, assembled[23:0]} and `imem_addr`=`widx`×4.
  - Increment `widx` and `words_loaded`.
- Next-state decision on that same edge:
  - Word == 32'hFFFF_FFFF → FLUSH.
  - Otherwise, `widx` == DEPTH-1 (last slot filled with a non-sentinel) → ERR.
  - Otherwise, stay in LOAD.
- FLUSH → RUN unconditionally after one cycle.
- RUN:
  - `run_cycles` increments each cycle, saturating.
  - `end_program`==1 → HALT. The cycle in which `end_program` is sampled high is counted.
- HALT and ERR are sticky. `restart`==1 → LOAD, clearing `bc`, `widx`, `words_loaded` and `run_cycles`. `restart` in any other state is ignored.
- A partial word (bc≠0) left when `restart` fires is discarded.
- `end_program` outside RUN is ignored.

## Timing
- Reset (`reset`=0, asynchronous) produces these output values:
  - state=LOAD, `in_ready`=1, `cpu_reset`=1.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `words_loaded`=0, `run_cycles`=0, `done`=0, `error`=0.
  - `bc`=0, `widx`=0.
- Reset mid-operation aborts immediately; there is no partial write strobe after reset is released.
- Throughput: one byte per cycle. A word write is visible 1 cycle after its 4th byte is accepted, and `imem_we` is high for exactly that one cycle.
- Sentinel path:
  - `imem_we` is high in FLUSH.
  - `cpu_reset` falls on the edge that enters RUN, one cycle after the sentinel write strobe, so every word is committed before the first fetch.
- `in_ready` falls in the same cycle as the final write strobe (sentinel or overflow).
- `cpu_reset` rises and `done` rises on the edge after `end_program` is sampled high.
- `restart` takes effect on the next edge; `in_ready`=1 in the following cycle.

## Test plan
- Stream bytes 13 05 A0 00, then FF FF FF FF, with `in_valid` held high.
  - Write 1: addr 0, data 0x00A00513.
  - Write 2: addr 4, data 0xFFFFFFFF.
  - `cpu_reset` falls 1 cycle after write 2; `words_loaded`=2.
- Toggle `in_valid` randomly (bubbles) during the same stream: identical writes and data; no byte dropped or duplicated.
- In RUN, hold `end_program` low for 10 cycles, then raise it.
  - `run_cycles`=11, `done`=1, `cpu_reset`=1.
  - Pulse `restart`: state returns to LOAD, counters are 0, `in_ready`=1.
- With DEPTH=4, stream 4 non-sentinel words.
  - Fourth write goes to addr 12.
  - `error`=1, `in_ready`=0, `cpu_reset` stays 1; a further `in_valid` is ignored.
- Assert `reset` low after 2 bytes of a word: all outputs return to reset values at once. Reload a fresh stream: the first write goes to addr 0 with no stale byte lanes.
- Raise `end_program` during LOAD: no state change; the load completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them from address 0 up to the all-ones sentinel, then gates the CPU reset.
module imem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  input  logic                       end_program,
  input  logic                       restart,
  output logic                       imem_we,
  output logic [63:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_reset,
  output logic [$clog2(DEPTH):0]     words_loaded,
  output logic [CNT_W-1:0]           run_cycles,
  output logic                       done,
  output logic                       error
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [2:0] {StLoad, StFlush, StRun, StHalt, StErr} state_e;

  state_e            state_q, state_d;
  logic [1:0]        bc_q, bc_d;
  logic [23:0]       asm_q, asm_d;
  logic [AW-1:0]     widx_q, widx_d;
  logic [AW:0]       words_q, words_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [63:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLoad;
      bc_q    <= '0;
      asm_q   <= '0;
      widx_q  <= '0;
      words_q <= '0;
      cyc_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      widx_q  <= widx_d;
      words_q <= words_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    asm_d   = asm_q;
    widx_d  = widx_q;
    words_d = words_q;
    cyc_d   = cyc_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word    = {in_data, asm_q};

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          bc_d = bc_q + 2'd1;
          unique case (bc_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = word;
              addr_d  = {{(62 - AW){1'b0}}, widx_q, 2'b00};
              widx_d  = widx_q + 1'b1;
              words_d = words_q + 1'b1;
              if (word == 32'hFFFF_FFFF) begin
                state_d = StFlush;
              end else if (widx_q == AW'(DEPTH - 1)) begin
                // Memory full without a sentinel: the program cannot be terminated.
                state_d = StErr;
              end
            end
          endcase
        end
      end
      StFlush: state_d = StRun;
      StRun: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (end_program) state_d = StHalt;
      end
      StHalt, StErr: begin
        if (restart) begin
          state_d = StLoad;
          bc_d    = '0;
          widx_d  = '0;
          words_d = '0;
          cyc_d   = '0;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  assign in_ready     = (state_q == StLoad);
  assign cpu_reset    = (state_q != StRun);
  assign done         = (state_q == StHalt);
  assign error        = (state_q == StErr);
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = words_q;
  assign run_cycles   = cyc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a DEPTH=256 instance for the main flows and a DEPTH=4
// instance for the overflow path.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, end_program = 1'b0, restart = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, imem_we, cpu_reset, done, error;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata, run_cycles;
  logic [8:0]  words_loaded;

  logic        in_valid4 = 1'b0, end_program4 = 1'b0, restart4 = 1'b0;
  logic [7:0]  in_data4 = '0;
  logic        in_ready4, imem_we4, cpu_reset4, done4, error4;
  logic [63:0] imem_addr4;
  logic [31:0] imem_wdata4, run_cycles4;
  logic [2:0]  words_loaded4;

  int checks = 0;
  int failures = 0;

  logic [63:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  imem_loader #(.DEPTH(256), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .end_program(end_program), .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .words_loaded(words_loaded),
    .run_cycles(run_cycles), .done(done), .error(error)
  );

  imem_loader #(.DEPTH(4), .CNT_W(32)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .end_program(end_program4), .restart(restart4), .imem_we(imem_we4),
    .imem_addr(imem_addr4), .imem_wdata(imem_wdata4), .cpu_reset(cpu_reset4),
    .words_loaded(words_loaded4), .run_cycles(run_cycles4), .done(done4), .error(error4)
  );

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    in_valid4 = 1'b1;
    in_data4  = b;
    tick();
    in_valid4 = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".cpu_reset"}, 64'(cpu_reset), 64'd1);
    chk({tag, ".imem_we"}, 64'(imem_we), 64'd0);
    chk({tag, ".imem_addr"}, imem_addr, 64'd0);
    chk({tag, ".imem_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, ".words"}, 64'(words_loaded), 64'd0);
    chk({tag, ".run_cycles"}, 64'(run_cycles), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
    chk({tag, ".error"}, 64'(error), 64'd0);
  endtask

  logic [7:0] prog [8];
  int idx, guard;
  bit v;

  initial begin
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'hA0; prog[3] = 8'h00;
    prog[4] = 8'hFF; prog[5] = 8'hFF; prog[6] = 8'hFF; prog[7] = 8'hFF;

    // Reset state
    tick(); tick();
    chk_reset_vals("rst");
    reset = 1'b1;
    tick();

    // Back-to-back stream
    send(8'h13); send(8'h05); send(8'hA0);
    chk("b2b.no_early_we", 64'(imem_we), 64'd0);
    send(8'h00);
    chk("b2b.w1_we", 64'(imem_we), 64'd1);
    chk("b2b.w1_addr", imem_addr, 64'd0);
    chk("b2b.w1_data", 64'(imem_wdata), 64'h00A0_0513);
    chk("b2b.w1_words", 64'(words_loaded), 64'd1);
    send(8'hFF);
    chk("b2b.we_one_cycle", 64'(imem_we), 64'd0);
    send(8'hFF); send(8'hFF); send(8'hFF);
    chk("b2b.w2_we", 64'(imem_we), 64'd1);
    chk("b2b.w2_addr", imem_addr, 64'd4);
    chk("b2b.w2_data", 64'(imem_wdata), 64'hFFFF_FFFF);
    chk("b2b.w2_in_ready", 64'(in_ready), 64'd0);
    chk("b2b.w2_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("b2b.words", 64'(words_loaded), 64'd2);
    tick();
    chk("b2b.run_we", 64'(imem_we), 64'd0);
    chk("b2b.run_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("b2b.run_cycles0", 64'(run_cycles), 64'd0);

    // RUN for 10 cycles, then end_program
    repeat (10) tick();
    chk("run.cycles10", 64'(run_cycles), 64'd10);
    chk("run.done_low", 64'(done), 64'd0);
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    chk("halt.cycles", 64'(run_cycles), 64'd11);
    chk("halt.done", 64'(done), 64'd1);
    chk("halt.cpu_reset", 64'(cpu_reset), 64'd1);
    chk("halt.in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("halt.sticky_cycles", 64'(run_cycles), 64'd11);
    chk("halt.sticky_done", 64'(done), 64'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart.in_ready", 64'(in_ready), 64'd1);
    chk("restart.words", 64'(words_loaded), 64'd0);
    chk("restart.cycles", 64'(run_cycles), 64'd0);
    chk("restart.done", 64'(done), 64'd0);

    // Same stream with random bubbles
    wr_addr_q.delete();
    wr_data_q.delete();
    idx = 0;
    guard = 0;
    while (idx < 8 && guard < 200) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? prog[idx] : 8'($urandom);
      tick();
      if (v) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bub.finished", 64'(idx), 64'd8);
    tick();
    chk("bub.nwrites", 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      chk("bub.w1_addr", wr_addr_q[0], 64'd0);
      chk("bub.w1_data", 64'(wr_data_q[0]), 64'h00A0_0513);
      chk("bub.w2_addr", wr_addr_q[1], 64'd4);
      chk("bub.w2_data", 64'(wr_data_q[1]), 64'hFFFF_FFFF);
    end
    chk("bub.words", 64'(words_loaded), 64'd2);
    chk("bub.cpu_reset", 64'(cpu_reset), 64'd0);

    // end_program outside RUN is ignored
    end_program = 1'b1;
    tick();
    end_program = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    end_program = 1'b1;
    tick();
    chk("ep_load.in_ready", 64'(in_ready), 64'd1);
    chk("ep_load.done", 64'(done), 64'd0);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    chk("ep_load.w_addr", imem_addr, 64'd0);
    chk("ep_load.w_data", 64'(imem_wdata), 64'h4433_2211);
    end_program = 1'b0;
    send(8'hFF); send(8'hFF); send(8'hFF); send(8'hFF);
    chk("ep_load.sent_addr", imem_addr, 64'd4);
    chk("ep_load.sent_we", 64'(imem_we), 64'd1);
    tick();
    chk("ep_load.run", 64'(cpu_reset), 64'd0);

    // Reset mid-run and mid-word
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_run");
    tick();
    reset = 1'b1;
    tick();
    send(8'hAA); send(8'hBB);
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid.no_strobe", 64'(imem_we), 64'd0);
    send(8'h01); send(8'h02); send(8'h03);
    chk("rst_mid.no_early_we", 64'(imem_we), 64'd0);
    send(8'h04);
    chk("rst_mid.we", 64'(imem_we), 64'd1);
    chk("rst_mid.addr", imem_addr, 64'd0);
    chk("rst_mid.data", 64'(imem_wdata), 64'h0403_0201);

    // DEPTH=4 overflow
    for (int w = 0; w < 4; w++) begin
      send4(8'(w + 1)); send4(8'h00); send4(8'h00); send4(8'h00);
      if (w == 2) begin
        chk("ovf.w3_error", 64'(error4), 64'd0);
        chk("ovf.w3_in_ready", 64'(in_ready4), 64'd1);
      end
    end
    chk("ovf.w4_we", 64'(imem_we4), 64'd1);
    chk("ovf.w4_addr", imem_addr4, 64'd12);
    chk("ovf.w4_data", 64'(imem_wdata4), 64'd4);
    chk("ovf.error", 64'(error4), 64'd1);
    chk("ovf.in_ready", 64'(in_ready4), 64'd0);
    chk("ovf.cpu_reset", 64'(cpu_reset4), 64'd1);
    chk("ovf.words", 64'(words_loaded4), 64'd4);
    in_valid4 = 1'b1;
    in_data4  = 8'h55;
    repeat (5) tick();
    in_valid4 = 1'b0;
    chk("ovf.ignored_we", 64'(imem_we4), 64'd0);
    chk("ovf.sticky_error", 64'(error4), 64'd1);
    chk("ovf.sticky_words", 64'(words_loaded4), 64'd4);
    chk("ovf.sticky_cpu_reset", 64'(cpu_reset4), 64'd1);
    restart4 = 1'b1;
    tick();
    restart4 = 1'b0;
    chk("ovf.restart_ready", 64'(in_ready4), 64'd1);
    chk("ovf.restart_error", 64'(error4), 64'd0);
    chk("ovf.restart_words", 64'(words_loaded4), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
